// File: rtl/ir_drv_pkg.sv
// rtl/ir_drv_pkg.sv - shared types and helpers for the IR LED flash sequencer
package ir_drv_pkg;

    localparam int NLEGS_DEF = 8;
    localparam int LEG_MAX   = 15;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN,
        COOL
    } state_t;

    // Thermometer code with the lowest `level` bits set; callers truncate to their leg count.
    function automatic logic [LEG_MAX-1:0] therm(input logic [3:0] level);
        therm = LEG_MAX'((16'd1 << level) - 16'd1);
    endfunction

    // Requested leg count limited to the number of legs physically present.
    function automatic logic [3:0] clamp_level(input logic [3:0] lvl, input logic [3:0] nmax);
        clamp_level = (lvl > nmax) ? nmax : lvl;
    endfunction

endpackage

// File: rtl/ir_step_timer.sv
// rtl/ir_step_timer.sv - loadable down-counter shared by step, hold and cool phases
module ir_step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/ir_flash_ctrl.sv
// rtl/ir_flash_ctrl.sv - soft-start/hold/ramp-down/cooldown sequencer for the IR leg drivers
module ir_flash_ctrl
    import ir_drv_pkg::*;
#(
    parameter int NLEGS  = ir_drv_pkg::NLEGS_DEF,
    parameter int STEP_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              trigger,
    input  logic [3:0]        cfg_level,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [LEN_W-1:0]  cfg_hold,
    input  logic [LEN_W-1:0]  cfg_cool,
    output logic [NLEGS-1:0]  ng_en,
    output logic              busy,
    output logic              done,
    output logic              trig_drop,
    output logic              abort
);

    state_t            state;
    logic [3:0]        level;
    logic [3:0]        lvl_l;
    logic [STEP_W-1:0] step_l;
    logic [LEN_W-1:0]  hold_l;
    logic [LEN_W-1:0]  cool_l;

    logic [3:0]        in_level;
    logic [STEP_W-1:0] in_step;
    logic [LEN_W-1:0]  in_hold;
    logic [3:0]        level_up;
    logic [3:0]        level_dn;
    logic [LEN_W-1:0]  step_ext;
    logic [LEN_W-1:0]  cool_m1;
    logic              tmr_load;
    logic [LEN_W-1:0]  tmr_val;
    logic              expire;

    assign in_level = clamp_level(cfg_level, 4'(NLEGS));
    assign in_step  = (cfg_step == '0) ? STEP_W'(1) : cfg_step;
    assign in_hold  = (cfg_hold == '0) ? LEN_W'(1) : cfg_hold;
    assign level_up = level + 4'd1;
    assign level_dn = level - 4'd1;
    assign step_ext = LEN_W'(step_l - STEP_W'(1));
    assign cool_m1  = (cool_l == '0) ? '0 : cool_l - LEN_W'(1);

    // Timer reload: armed with the length of whichever phase the next level change starts.
    always_comb begin
        tmr_load = 1'b1;
        tmr_val  = step_ext;
        case (state)
            IDLE: begin
                tmr_val = (in_level == 4'd1) ? in_hold - LEN_W'(1)
                                             : LEN_W'(in_step - STEP_W'(1));
            end
            RAMP_UP: begin
                tmr_load = expire;
                if (level_up == lvl_l) begin
                    tmr_val = hold_l - LEN_W'(1);
                end
            end
            HOLD, RAMP_DOWN: begin
                tmr_load = expire;
                if (level == 4'd1) begin
                    tmr_val = cool_m1;
                end
            end
            COOL: begin
                tmr_load = 1'b0;
            end
            default: begin
                tmr_load = 1'b1;
            end
        endcase
    end

    ir_step_timer #(
        .W(LEN_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (expire)
    );

    // Flash sequencer; ng_en is written alongside level so the drivers see one clean register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            level     <= 4'd0;
            lvl_l     <= 4'd0;
            step_l    <= '0;
            hold_l    <= '0;
            cool_l    <= '0;
            ng_en     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            trig_drop <= 1'b0;
            abort     <= 1'b0;
        end else begin
            done      <= 1'b0;
            trig_drop <= 1'b0;
            abort     <= 1'b0;
            if (state == IDLE) begin
                if (trigger) begin
                    // A trigger coinciding with the done pulse still falls inside the duty window.
                    if (!enable || done) begin
                        trig_drop <= 1'b1;
                    end else if (in_level != 4'd0) begin
                        lvl_l  <= in_level;
                        step_l <= in_step;
                        hold_l <= in_hold;
                        cool_l <= cfg_cool;
                        level  <= 4'd1;
                        ng_en  <= NLEGS'(therm(4'd1));
                        busy   <= 1'b1;
                        state  <= (in_level == 4'd1) ? HOLD : RAMP_UP;
                    end
                end
            end else if (!enable) begin
                state     <= IDLE;
                level     <= 4'd0;
                ng_en     <= '0;
                busy      <= 1'b0;
                abort     <= 1'b1;
                trig_drop <= trigger;
            end else begin
                trig_drop <= trigger;
                if (expire) begin
                    case (state)
                        RAMP_UP: begin
                            level <= level_up;
                            ng_en <= NLEGS'(therm(level_up));
                            if (level_up == lvl_l) begin
                                state <= HOLD;
                            end
                        end
                        HOLD, RAMP_DOWN: begin
                            level <= level_dn;
                            ng_en <= NLEGS'(therm(level_dn));
                            if (level == 4'd1) begin
                                if (cool_l == '0) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state <= COOL;
                                end
                            end else begin
                                state <= RAMP_DOWN;
                            end
                        end
                        COOL: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ir_flash_ctrl.sv
// tb/tb_ir_flash_ctrl.sv - self-checking bench for ir_flash_ctrl
module tb_ir_flash_ctrl;

    localparam int NL = 8;
    localparam int SW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          trigger;
    logic [3:0]    cfg_level;
    logic [SW-1:0] cfg_step;
    logic [LW-1:0] cfg_hold;
    logic [LW-1:0] cfg_cool;
    logic [NL-1:0] ng_en;
    logic          busy;
    logic          done;
    logic          trig_drop;
    logic          abort;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ir_flash_ctrl #(.NLEGS(NL), .STEP_W(SW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .trigger   (trigger),
        .cfg_level (cfg_level),
        .cfg_step  (cfg_step),
        .cfg_hold  (cfg_hold),
        .cfg_cool  (cfg_cool),
        .ng_en     (ng_en),
        .busy      (busy),
        .done      (done),
        .trig_drop (trig_drop),
        .abort     (abort)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cfg(input int l, input int s, input int p, input int c);
        cfg_level = 4'(l);
        cfg_step  = SW'(s);
        cfg_hold  = LW'(p);
        cfg_cool  = LW'(c);
    endtask

    function automatic int nominal_ng(input int c);
        if (c >= 1 && c <= 2)   return 'h01;
        if (c >= 3 && c <= 4)   return 'h03;
        if (c >= 5 && c <= 8)   return 'h07;
        if (c >= 9 && c <= 10)  return 'h03;
        if (c >= 11 && c <= 12) return 'h01;
        return 0;
    endfunction

    // mode 0 plain, 1 overlapping triggers, 2 config change, 3 enable drop, 4 sync reset
    task automatic run_nominal(input int mode);
        bit killed;
        set_cfg(3, 2, 4, 5);
        enable  = 1'b1;
        trigger = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick;
            trigger = 1'b0;
            killed = (mode == 3 && c >= 7) || (mode == 4 && c >= 5);
            chk($sformatf("m%0d ng_en@%0d", mode, c), int'(ng_en), killed ? 0 : nominal_ng(c));
            chk($sformatf("m%0d busy@%0d", mode, c), int'(busy), (!killed && c <= 17) ? 1 : 0);
            chk($sformatf("m%0d done@%0d", mode, c), int'(done), (!killed && c == 18) ? 1 : 0);
            chk($sformatf("m%0d trig_drop@%0d", mode, c), int'(trig_drop),
                (mode == 1 && (c == 7 || c == 19)) ? 1 : 0);
            chk($sformatf("m%0d abort@%0d", mode, c), int'(abort), (mode == 3 && c == 7) ? 1 : 0);
            if (mode == 1 && (c == 6 || c == 18)) trigger = 1'b1;
            if (mode == 2 && c == 2) cfg_level = 4'd8;
            if (mode == 3 && c == 6) enable = 1'b0;
            if (mode == 3 && c == 7) enable = 1'b1;
            if (mode == 4 && c == 4) rst = 1'b1;
            if (mode == 4 && c == 5) rst = 1'b0;
        end
    endtask

    typedef struct {
        int l;
        int s;
        int p;
        int c;
        int peak;
        int z;
        int dn;
    } vec_t;

    // Timeline of one flash at offset d cycles after acceptance.
    task automatic timeline(input int d, input int l, input int s, input int p, input int c,
                            output int lvl, output bit bsy, output bit dn);
        int r0;
        int z;
        r0 = (l - 1) * s + p + 1;
        z  = r0 + (l - 1) * s;
        if (d < 1 + (l - 1) * s)  lvl = (d - 1) / s + 1;
        else if (d < r0)          lvl = l;
        else if (d < z)           lvl = l - 1 - (d - r0) / s;
        else                      lvl = 0;
        bsy = (d < z + c);
        dn  = (d == z + c);
    endtask

    initial begin
        vec_t tbl[6];
        int   peak;
        int   zc;
        int   dc;
        bit   seen;
        bit   m_act;
        int   m_d;
        int   ml, ms, mp, mc;
        int   e_lvl;
        bit   e_busy, e_done, e_drop, e_abort;
        bit   n_done, n_drop, n_abort;
        int   cl;

        rst = 1'b1;
        enable = 1'b1;
        trigger = 1'b0;
        set_cfg(3, 2, 4, 5);
        tick;
        tick;
        chk("reset ng_en", int'(ng_en), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset trig_drop", int'(trig_drop), 0);
        chk("reset abort", int'(abort), 0);
        rst = 1'b0;
        tick;

        for (int m = 0; m <= 4; m++) begin
            run_nominal(m);
            tick;
        end
        run_nominal(0);
        tick;

        // Config-driven vectors: expected peak code, cycle ng_en returns to 0, done cycle.
        tbl[0] = '{3, 2, 4, 5, 'h07, 13, 18};
        tbl[1] = '{12, 0, 0, 0, 'hFF, 16, 16};
        tbl[2] = '{1, 3, 2, 0, 'h01, 3, 3};
        tbl[3] = '{8, 1, 3, 2, 'hFF, 18, 20};
        tbl[4] = '{5, 4, 1, 1, 'h1F, 34, 35};
        tbl[5] = '{0, 2, 2, 2, 0, -1, -1};
        for (int i = 0; i < 6; i++) begin
            set_cfg(tbl[i].l, tbl[i].s, tbl[i].p, tbl[i].c);
            trigger = 1'b1;
            peak = 0;
            zc = -1;
            dc = -1;
            seen = 1'b0;
            for (int c = 1; c <= 60; c++) begin
                tick;
                trigger = 1'b0;
                if (int'(ng_en) > peak) peak = int'(ng_en);
                if (ng_en != 0) seen = 1'b1;
                if (seen && ng_en == 0 && zc < 0) zc = c;
                if (done && dc < 0) dc = c;
            end
            chk($sformatf("vec%0d peak", i), peak, tbl[i].peak);
            chk($sformatf("vec%0d zero cycle", i), zc, tbl[i].z);
            chk($sformatf("vec%0d done cycle", i), dc, tbl[i].dn);
        end

        // Trigger with enable low: drop pulse only.
        set_cfg(3, 2, 4, 5);
        enable = 1'b0;
        trigger = 1'b1;
        tick;
        trigger = 1'b0;
        enable = 1'b1;
        chk("dis trig_drop", int'(trig_drop), 1);
        chk("dis busy", int'(busy), 0);
        chk("dis ng_en", int'(ng_en), 0);
        tick;
        chk("dis trig_drop clear", int'(trig_drop), 0);
        chk("dis busy stays low", int'(busy), 0);

        // Randomised traffic against the timeline model.
        m_act = 1'b0;
        m_d = 0;
        ml = 0; ms = 1; mp = 1; mc = 0;
        e_done = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            trigger = ($urandom_range(0, 7) == 0);
            enable  = ($urandom_range(0, 63) != 0);
            set_cfg($urandom_range(0, 15), $urandom_range(0, 3),
                    $urandom_range(0, 5), $urandom_range(0, 4));
            n_done = 1'b0;
            n_drop = 1'b0;
            n_abort = 1'b0;
            if (m_act) begin
                if (trigger) n_drop = 1'b1;
                if (!enable) begin
                    m_act = 1'b0;
                    n_abort = 1'b1;
                    e_lvl = 0;
                    e_busy = 1'b0;
                end else begin
                    m_d++;
                    timeline(m_d, ml, ms, mp, mc, e_lvl, e_busy, n_done);
                    if (n_done) m_act = 1'b0;
                end
            end else begin
                e_lvl = 0;
                e_busy = 1'b0;
                cl = (int'(cfg_level) > NL) ? NL : int'(cfg_level);
                if (trigger) begin
                    if (!enable || e_done) begin
                        n_drop = 1'b1;
                    end else if (cl != 0) begin
                        ml = cl;
                        ms = (cfg_step == 0) ? 1 : int'(cfg_step);
                        mp = (cfg_hold == 0) ? 1 : int'(cfg_hold);
                        mc = int'(cfg_cool);
                        m_act = 1'b1;
                        m_d = 1;
                        timeline(m_d, ml, ms, mp, mc, e_lvl, e_busy, n_done);
                    end
                end
            end
            e_done = n_done;
            e_drop = n_drop;
            e_abort = n_abort;
            tick;
            chk($sformatf("rnd%0d ng_en", it), int'(ng_en), (1 << e_lvl) - 1);
            chk($sformatf("rnd%0d busy", it), int'(busy), int'(e_busy));
            chk($sformatf("rnd%0d done", it), int'(done), int'(e_done));
            chk($sformatf("rnd%0d trig_drop", it), int'(trig_drop), int'(e_drop));
            chk($sformatf("rnd%0d abort", it), int'(abort), int'(e_abort));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
